// File: rtl/io_master_pkg.sv
// rtl/io_master_pkg.sv - shared types, constants and default timing for io_master
package io_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_WAIT_END,
        S_READ,
        S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        W_BASE = 2'd0,
        W_EXP  = 2'd1,
        W_MOD  = 2'd2,
        W_GO   = 2'd3
    } word_idx_t;

    localparam logic [31:0] GO_WORD = 32'h0;

    localparam int DEF_SETUP_CYC   = 2;
    localparam int DEF_STROBE_CYC  = 4;
    localparam int DEF_GAP_CYC     = 4;
    localparam int DEF_READ_CYC    = 2;
    localparam int DEF_TIMEOUT_CYC = 1000000;

    // Counters hold (cycles - 1) down to zero, so log2 of the largest phase is enough.
    function automatic int cnt_width(input int max_cyc);
        return (max_cyc < 2) ? 1 : $clog2(max_cyc);
    endfunction

endpackage

// File: rtl/io_master_if.sv
// rtl/io_master_if.sv - shared data bus and strobe handshake between master and responder
interface io_master_if;
    logic [31:0] data_o;
    logic        data_oe;
    logic        write;
    logic        oe;
    logic        io_end;
    logic [31:0] data_i;

    modport master (
        output data_o,
        output data_oe,
        output write,
        output oe,
        input  io_end,
        input  data_i
    );

    modport slave (
        input  data_o,
        input  data_oe,
        input  write,
        input  oe,
        output io_end,
        output data_i
    );
endinterface

// File: rtl/io_cycle_timer.sv
// rtl/io_cycle_timer.sv - saturating down-counter timing every io_master phase
module io_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/io_master.sv
// rtl/io_master.sv - four-write strobe master that launches an RSA job and reads back the result
module io_master
    import io_master_pkg::*;
#(
    parameter int SETUP_CYC   = DEF_SETUP_CYC,
    parameter int STROBE_CYC  = DEF_STROBE_CYC,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int READ_CYC    = DEF_READ_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] base_in,
    input  logic [31:0] exp_in,
    input  logic [31:0] mod_in,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [31:0] result,
    io_master_if.master bus
);

    localparam int MAX_A   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_B   = (GAP_CYC > READ_CYC) ? GAP_CYC : READ_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
    localparam int CNT_W   = cnt_width(MAX_CYC);

    state_t           state;
    state_t           state_next;
    word_idx_t        idx;
    logic [31:0]      base_q;
    logic [31:0]      exp_q;
    logic [31:0]      mod_q;
    logic [31:0]      cur_word;
    logic [CNT_W-1:0] load_val;
    logic             expired;

    // The timer reloads on every state change, so each phase starts from a fresh count.
    io_cycle_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .rstn     (rstn),
        .load     (state_next != state),
        .load_val (load_val),
        .enable   (state != S_IDLE),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (start) state_next = S_SETUP;
            S_SETUP:    if (expired) state_next = S_STROBE;
            S_STROBE:   if (expired) state_next = S_GAP;
            S_GAP:      if (expired) state_next = (idx == W_GO) ? S_WAIT_END : S_SETUP;
            S_WAIT_END: begin
                if (bus.io_end) begin
                    state_next = S_READ;
                end else if (expired) begin
                    state_next = S_IDLE;
                end
            end
            S_READ:     if (expired) state_next = S_FINISH;
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (state_next)
            S_SETUP:    load_val = CNT_W'(SETUP_CYC - 1);
            S_STROBE:   load_val = CNT_W'(STROBE_CYC - 1);
            S_GAP:      load_val = CNT_W'(GAP_CYC - 1);
            S_WAIT_END: load_val = CNT_W'(TIMEOUT_CYC - 1);
            S_READ:     load_val = CNT_W'(READ_CYC - 1);
            default:    load_val = '0;
        endcase
    end

    always_comb begin
        case (idx)
            W_BASE:  cur_word = base_q;
            W_EXP:   cur_word = exp_q;
            W_MOD:   cur_word = mod_q;
            default: cur_word = GO_WORD;
        endcase
    end

    always_comb begin
        bus.data_o  = '0;
        bus.data_oe = 1'b0;
        bus.write   = 1'b0;
        bus.oe      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            S_SETUP, S_GAP: begin
                bus.data_o  = cur_word;
                bus.data_oe = 1'b1;
                busy        = 1'b1;
            end
            S_STROBE: begin
                bus.data_o  = cur_word;
                bus.data_oe = 1'b1;
                bus.write   = 1'b1;
                busy        = 1'b1;
            end
            S_WAIT_END: busy = 1'b1;
            S_READ: begin
                bus.oe = 1'b1;
                busy   = 1'b1;
            end
            S_FINISH: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            idx     <= W_BASE;
            result  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= (state == S_WAIT_END) && !bus.io_end && expired;
            if ((state == S_IDLE) && start) begin
                base_q <= base_in;
                exp_q  <= exp_in;
                mod_q  <= mod_in;
                idx    <= W_BASE;
            end
            if ((state == S_GAP) && expired && (idx != W_GO)) begin
                idx <= word_idx_t'(idx + 2'd1);
            end
            if ((state == S_READ) && expired) begin
                result <= bus.data_i;
            end
        end
    end

endmodule

// File: doc/io_master.md
IO_MASTER -- requirements
Module: io_master

Interface
REQ-001 Parameters SHALL be:
- SETUP_CYC, 2, data-valid cycles before write rises.
- STROBE_CYC, 4, write high cycles.
- GAP_CYC, 4, write low cycles after each strobe.
- READ_CYC, 2, oe-high cycles before sampling.
- TIMEOUT_CYC, 1000000, max cycles waiting for io_end.
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its posedge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_in  in  32  RSA base.
- exp_in  in  32  RSA exponent.
- mod_in  in  32  RSA modulus.
- io_end  in  1  responder completion level.
- data_i  in  32  bus read path.
- data_o  out  32  bus write path.
- data_oe  out  1  master drives bus when high.
- write  out  1  write strobe level to responder.
- oe  out  1  responder drives result onto bus when high.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse: result valid.
- timeout  out  1  one-cycle pulse: io_end never arrived.
- result  out  32  last captured result.

Function
REQ-003 States SHALL be IDLE, SETUP, STROBE, GAP, WAIT_END, READ, FINISH.
REQ-004 IDLE with start=1 SHALL latch base_in, exp_in and mod_in, clear the word index to 0, set busy and go to SETUP; start in other states SHALL be ignored.
REQ-005 SETUP SHALL drive data_oe=1 and data_o=word[index] (0: base, 1: exp, 2: mod, 3: 32'h0 go-word) for SETUP_CYC cycles, then go to STROBE.
REQ-006 STROBE SHALL hold write=1 with data_o stable for STROBE_CYC cycles, then go to GAP.
REQ-007 GAP SHALL hold write=0 with data_o stable for GAP_CYC cycles; then index<3 SHALL increment and go to SETUP, and index=3 SHALL go to WAIT_END.
REQ-008 Exactly four write pulses SHALL be issued per transaction; the fourth, a data-don't-care pulse, triggers the responder's computation.
REQ-009 WAIT_END SHALL drop data_oe to 0 and count cycles; io_end=1 SHALL go to READ; the count reaching TIMEOUT_CYC first SHALL pulse timeout and return to IDLE with busy=0.
REQ-010 READ SHALL assert oe=1 for READ_CYC cycles, capture data_i into result on the last of them, then go to FINISH.
REQ-011 FINISH SHALL deassert oe, pulse done for one cycle, clear busy and return to IDLE.
REQ-012 data_oe and oe SHALL never both be 1 in the same cycle; at least one cycle with both low SHALL separate drive handover.
REQ-013 Each cycle counter SHALL be wide enough for its parameter, SHALL saturate rather than wrap, and SHALL reload at every state entry.
REQ-014 result SHALL be held until the next successful READ; a timeout SHALL leave it unchanged.
REQ-015 io_end high outside WAIT_END SHALL be ignored.

Reset
REQ-016 rstn=0 SHALL force IDLE immediately and drive write, oe, data_oe, busy, done and timeout to 0, and data_o, result, latched words and counters to 0, including mid-transaction.
REQ-017 The first start after rstn release SHALL be accepted no earlier than the first clk edge with rstn=1.

Structure
REQ-018 Package io_master_pkg SHALL hold the state enum, word-index encoding, go-word constant and default timing parameters.
REQ-019 A sub-module io_cycle_timer (load value, enable, expired flag) SHALL implement all phase and timeout counting.

Verification
REQ-020 base=4, exp=13, mod=497 with a responder model -> four write pulses, each STROBE_CYC high, with data 4, 13, 497, 0; after io_end, result=445 and a single done pulse.
REQ-021 Responder never asserts io_end -> timeout pulses exactly TIMEOUT_CYC cycles after WAIT_END entry, busy=0, result unchanged.
REQ-022 rstn low during the second STROBE -> all outputs 0 asynchronously; a new start then yields a full four-pulse sequence.
REQ-023 start held high through the whole transaction -> a second transaction begins only after done, never overlapping.
REQ-024 Assertion monitor over all tests -> no cycle with data_oe=1 and oe=1; data_o constant while write=1.
REQ-025 io_end pulsed during SETUP, then asserted normally -> no early READ; read occurs only after the fourth pulse.
